// File: rtl/pwm_pkg.sv
// Shared types and helpers for the pwm_bank PWM generator.
// Soft-ramp (fade) mode is compiled in with the PWM_RAMP_EN macro.
package pwm_pkg;

    localparam int DUTY_W_MAX = 16;

    // Wide enough for any supported duty width; callers zero-extend/truncate.
    typedef logic [DUTY_W_MAX-1:0] duty_t;

`ifdef PWM_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    function automatic int unsigned max_duty(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // One fade step from active toward target, saturating exactly at target.
    // The extra bit keeps the sums from wrapping at 0 or full scale.
    function automatic duty_t ramp_next(input duty_t active, input duty_t target, input duty_t step);
        logic [DUTY_W_MAX:0] a;
        logic [DUTY_W_MAX:0] t;
        logic [DUTY_W_MAX:0] s;
        duty_t               result;
        a      = {1'b0, active};
        t      = {1'b0, target};
        s      = {1'b0, step};
        result = target;
        if (a + s < t) begin
            result = duty_t'(a + s);
        end else if (t + s < a) begin
            result = duty_t'(a - s);
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: double-buffered duty (target/active), boundary commit and
// the registered compare output.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int    W    = 8,
    parameter duty_t STEP = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] duty_i,
    input  logic         capture_i,
    input  logic         commit_i,
    input  logic [W-1:0] cnt_i,
    input  logic         enable_i,
    output logic         pwm_o,
    output logic         ramping_o
);

    logic [W-1:0] target_q, target_d;
    logic [W-1:0] active_q, active_d;
    logic         pwm_q, pwm_d;

    // Without ramp STEP is full scale, so the step lands on target in one go.
    always_comb begin
        target_d = target_q;
        active_d = active_q;
        if (capture_i) begin
            target_d = duty_i;
        end
        if (commit_i) begin
            active_d = W'(ramp_next(duty_t'(active_q), duty_t'(target_q), STEP));
        end
        pwm_d = enable_i & (cnt_i < active_q);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            target_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm_o     = pwm_q;
    assign ramping_o = RAMP_ON && (active_q != target_q);

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: prescaler, shared period counter, pending-frame flag
// and CH channel instances. PWM_RAMP_EN selects soft-ramp commits.
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int CH       = 10,
    parameter int W        = 8,
    parameter int PRESCALE = 98,
    parameter int STEP     = 1
) (
    input  logic          clk50M,
    input  logic          rst_n,
    input  logic [CH*W-1:0] frame_i,
    input  logic          frame_valid_i,
    input  logic          enable_i,
    output logic [CH-1:0] pwm_o,
    output logic          period_start_o,
    output logic          busy_o
);

    localparam int           PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] MAX       = W'(max_duty(W));
    localparam duty_t        RAMP_STEP = RAMP_ON ? duty_t'(STEP) : duty_t'(MAX);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [W-1:0]     cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             period_start_q;
    logic             tick;
    logic             wrap;
    logic [CH-1:0]    ramping;

    always_comb begin
        tick  = (pre_q == PRE_W'(PRESCALE - 1));
        wrap  = tick && (cnt_q == MAX - W'(1));
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
        // A strobe on the boundary cycle keeps the frame pending for the next one.
        pend_d = pend_q;
        if (frame_valid_i) begin
            pend_d = 1'b1;
        end else if (wrap) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk50M) begin
        if (!rst_n) begin
            pre_q          <= '0;
            cnt_q          <= '0;
            pend_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            pre_q          <= pre_d;
            cnt_q          <= cnt_d;
            pend_q         <= pend_d;
            period_start_q <= wrap;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            pwm_channel #(
                .W    (W),
                .STEP (RAMP_STEP)
            ) u_ch (
                .clk_i     (clk50M),
                .rst_n_i   (rst_n),
                .duty_i    (frame_i[gi*W +: W]),
                .capture_i (frame_valid_i),
                .commit_i  (wrap),
                .cnt_i     (cnt_q),
                .enable_i  (enable_i),
                .pwm_o     (pwm_o[gi]),
                .ramping_o (ramping[gi])
            );
        end
    endgenerate

    assign period_start_o = period_start_q;
    assign busy_o         = pend_q | (|ramping);

endmodule

// File: tb/tb_pwm_bank.sv
// Bench for pwm_bank (CH=2, W=4, PRESCALE=2, STEP=4): stimulus queues the
// expected duties per period; a monitor checks every announced period.
`timescale 1ns/1ps
module tb_pwm_bank;

    localparam int PRE = 2;
    localparam int PER = 30;
`ifdef PWM_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    typedef struct {
        int d0;
        int d1;
        int busy;
    } exp_t;

    logic       clk50M = 1'b0;
    logic       rst_n;
    logic [7:0] frame_i;
    logic       frame_valid_i;
    logic       enable_i;
    logic [1:0] pwm_o;
    logic       period_start_o;
    logic       busy_o;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    pwm_bank #(
        .CH       (2),
        .W        (4),
        .PRESCALE (PRE),
        .STEP     (4)
    ) dut (
        .clk50M         (clk50M),
        .rst_n          (rst_n),
        .frame_i        (frame_i),
        .frame_valid_i  (frame_valid_i),
        .enable_i       (enable_i),
        .pwm_o          (pwm_o),
        .period_start_o (period_start_o),
        .busy_o         (busy_o)
    );

    always #5 clk50M = ~clk50M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int d0, input int d1, input int busy);
        exp_t e;
        e.d0   = d0;
        e.d1   = d1;
        e.busy = busy;
        exp_q.push_back(e);
    endtask

    // Called just after a posedge; drives the frame for exactly one edge.
    task automatic strobe(input int d1, input int d0);
        logic [3:0] a;
        logic [3:0] b;
        a = 4'(d1);
        b = 4'(d0);
        #1;
        frame_i       = {a, b};
        frame_valid_i = 1'b1;
        @(posedge clk50M);
        #1;
        frame_valid_i = 1'b0;
    endtask

    task automatic wait_pulse(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk50M);
            n++;
        end while (period_start_o !== 1'b1 && n < PER + 10);
        check({tag, " boundary pulse"}, period_start_o, 1);
    endtask

    // Monitor: each boundary with a queued expectation is followed by one
    // full period of sampled outputs.
    initial begin : monitor
        exp_t e;
        bit   prev_en;
        bit   exp0;
        bit   exp1;
        int   bad0;
        int   bad1;
        int   bad_ps;
        forever begin
            @(negedge clk50M);
            if (rst_n === 1'b1 && period_start_o === 1'b1) begin
                while (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("busy at boundary (d0=%0d d1=%0d)", e.d0, e.d1), busy_o, e.busy);
                    prev_en = enable_i;
                    bad0    = 0;
                    bad1    = 0;
                    bad_ps  = 0;
                    for (int k = 1; k <= PER; k++) begin
                        @(negedge clk50M);
                        exp0 = prev_en && (k <= e.d0 * PRE);
                        exp1 = prev_en && (k <= e.d1 * PRE);
                        if (pwm_o[0] !== exp0) bad0++;
                        if (pwm_o[1] !== exp1) bad1++;
                        if (period_start_o !== (k == PER)) bad_ps++;
                        prev_en = enable_i;
                    end
                    check($sformatf("ch0 waveform bad samples (duty %0d)", e.d0), bad0, 0);
                    check($sformatf("ch1 waveform bad samples (duty %0d)", e.d1), bad1, 0);
                    check("period_start placement bad samples", bad_ps, 0);
                    $display("period duty0=%0d duty1=%0d busy=%0d checked", e.d0, e.d1, e.busy);
                    if (period_start_o !== 1'b1) break;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst_n         = 1'b0;
        frame_i       = '0;
        frame_valid_i = 1'b0;
        enable_i      = 1'b1;

        // Reset and first boundary latency.
        repeat (3) @(posedge clk50M);
        @(negedge clk50M);
        check("reset pwm_o", pwm_o, 0);
        check("reset period_start_o", period_start_o, 0);
        check("reset busy_o", busy_o, 0);
        @(posedge clk50M);
        #1 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < PER + 10; i++) begin
            @(negedge clk50M);
            if (period_start_o === 1'b1) break;
            n++;
        end
        check("clocks from release to first boundary", n, PER);
        $display("first boundary after %0d clocks", n);

        // Basic duty, strobed mid-period.
        repeat (10) @(posedge clk50M);
        strobe(15, 5);
        @(negedge clk50M);
        check("busy after capture", busy_o, 1);
        if (RAMP) push(4, 4, 1);
        else      push(5, 15, 0);
        wait_pulse("P2");

        // Boundary collision: strobe lands on the wrap cycle.
        if (RAMP) begin
            push(5, 8, 1);
            push(9, 4, 1);
            push(9, 0, 0);
        end else begin
            push(5, 15, 1);
            push(9, 0, 0);
            push(9, 0, 0);
        end
        repeat (PER - 1) @(posedge clk50M);
        strobe(0, 9);
        wait_pulse("P3");
        wait_pulse("P4");
        wait_pulse("P5");

        // Enable dropped for 7 clocks mid-period.
        repeat (5) @(posedge clk50M);
        #1 enable_i = 1'b0;
        @(posedge clk50M);
        @(negedge clk50M);
        check("pwm_o gated by enable", pwm_o, 0);
        repeat (6) @(posedge clk50M);
        #1 enable_i = 1'b1;
        wait_pulse("P6");

        // Reset mid-operation, then ramp up from zero.
        repeat (5) @(posedge clk50M);
        #1 rst_n = 1'b0;
        @(posedge clk50M);
        @(negedge clk50M);
        check("mid reset busy_o", busy_o, 0);
        @(posedge clk50M);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk50M);
        strobe(3, 15);
        if (RAMP) begin
            push(4, 3, 1);
            push(8, 3, 1);
            push(12, 3, 1);
            push(15, 3, 0);
        end else begin
            push(15, 3, 0);
        end
        wait_pulse("Q1");
        if (RAMP) repeat (3) wait_pulse("Q ramp up");

        // Ramp down to zero.
        repeat (10) @(posedge clk50M);
        strobe(0, 0);
        if (RAMP) push(11, 0, 1);
        else      push(0, 0, 0);
        wait_pulse("ramp down first");
        wait_pulse("ramp down second");

        // Reset while a ramp may be in progress.
        repeat (5) @(posedge clk50M);
        #1 rst_n = 1'b0;
        @(posedge clk50M);
        @(negedge clk50M);
        check("reset mid-ramp pwm_o", pwm_o, 0);
        check("reset mid-ramp busy_o", busy_o, 0);
        check("reset mid-ramp period_start_o", period_start_o, 0);
        @(posedge clk50M);
        #1 rst_n = 1'b1;
        push(0, 0, 0);
        push(0, 0, 0);
        wait_pulse("R1");
        wait_pulse("R2");
        wait_pulse("R3");

        repeat (2) @(negedge clk50M);
        check("expectations left unchecked", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
